// File: rtl/usb_in_arb_pkg.sv
// Shared types and defaults for the bulk-IN packet arbiter.
package usb_in_arb_pkg;

    localparam int LEN_W_DEF         = 12;
    localparam int MAX_PKT_DEF       = 512;
    localparam int FLUSH_TIMEOUT_DEF = 64;

    // Source identifiers carried on m_tid
    localparam logic TID_DAP    = 1'b0;
    localparam logic TID_STREAM = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER0 = 2'd1,
        XFER1 = 2'd2
    } arb_state_e;

    // Force a requested length into the legal range 1..max_len
    function automatic int clamp_len(input int len, input int max_len);
        if (len < 1) begin
            return 1;
        end
        if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/usb_in_arbiter_rr_arb2.sv
// Two-way round-robin grant; the last winner loses the next tie.
module rr_arb2
    import usb_in_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic last_grant_q;
    logic last_grant_d;

    // Pick the single requester, or the one that did not win last time
    always_comb begin
        gnt_valid = |req;
        gnt_id    = (req == 2'b11) ? ~last_grant_q : req[1];
    end

    // Remember the winner only when the grant is actually taken
    always_comb begin
        last_grant_d = last_grant_q;
        if (en && gnt_valid) begin
            last_grant_d = gnt_id;
        end
    end

    // Reset to the stream id so the DAP source wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= TID_STREAM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/usb_in_arbiter.sv
// Packet-atomic arbiter sharing the WinUSB bulk-IN path between the DAP
// response stream and the trace byte FIFO, which is chunked into packets.
module usb_in_arbiter
    import usb_in_arb_pkg::*;
#(
    parameter int MAX_PKT       = MAX_PKT_DEF,
    parameter int LEN_W         = LEN_W_DEF,
    parameter int FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEF
) (
    input  logic             hclk,
    input  logic             reset,
    input  logic             enable,
    input  logic             s0_tvalid,
    output logic             s0_tready,
    input  logic [7:0]       s0_tdata,
    input  logic [LEN_W-1:0] s0_tlen,
    input  logic             s1_tvalid,
    output logic             s1_tready,
    input  logic [7:0]       s1_tdata,
    input  logic [LEN_W-1:0] s1_count,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [7:0]       m_tdata,
    output logic [LEN_W-1:0] m_tlen,
    output logic             m_tlast,
    output logic             m_tid,
    output logic             busy,
    output logic             err_len
);

    localparam int               TMR_W   = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(FLUSH_TIMEOUT);

    arb_state_e       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             tid_q, tid_d;
    logic             err_len_q, err_len_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic [1:0]       req;
    logic             gnt_valid;
    logic             gnt_id;
    logic             idle;
    logic             grant;
    logic             m_hs;
    logic [LEN_W-1:0] s0_len_clamped;
    logic [LEN_W-1:0] s1_len_clamped;
    logic             s0_len_bad;

    assign idle  = (state_q == IDLE);
    assign grant = idle & gnt_valid;
    assign m_hs  = m_tvalid & m_tready;

    // Requests: DAP whenever it has data, stream only for a full chunk or after timeout
    always_comb begin
        req[0] = enable & s0_tvalid;
        req[1] = enable & (s1_count != '0) & ((s1_count >= MAX_LEN) | (timer_q == TMR_MAX));
    end

    rr_arb2 u_rr_arb2 (
        .clk       (hclk),
        .reset     (reset),
        .en        (idle),
        .req       (req),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Packet lengths as they would be latched at grant time
    always_comb begin
        s0_len_clamped = LEN_W'(clamp_len(int'(s0_tlen), MAX_PKT));
        s0_len_bad     = (s0_tlen == '0) | (s0_tlen > MAX_LEN);
        s1_len_clamped = (s1_count >= MAX_LEN) ? MAX_LEN : s1_count;
    end

    // Route the granted source onto the USB side; the other source is held off
    always_comb begin
        m_tvalid  = 1'b0;
        m_tdata   = 8'h00;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        case (state_q)
            XFER0: begin
                m_tvalid  = s0_tvalid;
                m_tdata   = s0_tdata;
                s0_tready = m_tready;
            end
            XFER1: begin
                m_tvalid  = s1_tvalid;
                m_tdata   = s1_tdata;
                s1_tready = m_tready;
            end
            default: begin
            end
        endcase
    end

    // Grant latching in IDLE, byte countdown while a packet is in flight
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rem_d     = rem_q;
        tid_d     = tid_q;
        err_len_d = err_len_q;
        if (grant) begin
            tid_d = gnt_id;
            if (gnt_id == TID_DAP) begin
                len_d     = s0_len_clamped;
                err_len_d = err_len_q | s0_len_bad;
                state_d   = XFER0;
            end else begin
                len_d   = s1_len_clamped;
                state_d = XFER1;
            end
            rem_d = len_d;
        end else if (!idle && m_hs) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) begin
                state_d = IDLE;
            end
        end
    end

    // Flush timer: ages pending stream data, frozen while a stream packet runs
    always_comb begin
        timer_d = timer_q;
        if ((s1_count == '0) || (grant && (gnt_id == TID_STREAM))) begin
            timer_d = '0;
        end else if ((state_q != XFER1) && (timer_q != TMR_MAX)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // State and packet registers; reset drops any partial packet
    always_ff @(posedge hclk) begin
        if (reset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            rem_q     <= '0;
            tid_q     <= 1'b0;
            err_len_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            tid_q     <= tid_d;
            err_len_q <= err_len_d;
            timer_q   <= timer_d;
        end
    end

    // Registered packet attributes driven straight out
    always_comb begin
        busy    = !idle;
        m_tlen  = len_q;
        m_tid   = tid_q;
        m_tlast = !idle && (rem_q == LEN_W'(1));
        err_len = err_len_q;
    end

endmodule

// File: tb/tb_usb_in_arbiter.sv
// Self-checking bench for usb_in_arbiter: source models for both requesters,
// a byte scoreboard on the USB side and directed packet scenarios.
module tb_usb_in_arbiter;

    localparam int LEN_W = 12;

    logic             hclk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b1;
    logic             s0_tvalid = 1'b0;
    logic             s0_tready;
    logic [7:0]       s0_tdata = 8'h00;
    logic [LEN_W-1:0] s0_tlen = '0;
    logic             s1_tvalid = 1'b0;
    logic             s1_tready;
    logic [7:0]       s1_tdata = 8'h00;
    logic [LEN_W-1:0] s1_count = '0;
    logic             m_tvalid;
    logic             m_tready = 1'b1;
    logic [7:0]       m_tdata;
    logic [LEN_W-1:0] m_tlen;
    logic             m_tlast;
    logic             m_tid;
    logic             busy;
    logic             err_len;

    usb_in_arbiter dut (
        .hclk      (hclk),
        .reset     (reset),
        .enable    (enable),
        .s0_tvalid (s0_tvalid),
        .s0_tready (s0_tready),
        .s0_tdata  (s0_tdata),
        .s0_tlen   (s0_tlen),
        .s1_tvalid (s1_tvalid),
        .s1_tready (s1_tready),
        .s1_tdata  (s1_tdata),
        .s1_count  (s1_count),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tlen    (m_tlen),
        .m_tlast   (m_tlast),
        .m_tid     (m_tid),
        .busy      (busy),
        .err_len   (err_len)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        int tid;
        int len;
        int n;
        int first;
        int last;
    } pkt_t;

    typedef struct {
        int tlen_field;
        int exp_len;
        bit exp_err;
        bit bp;
    } vec_t;

    byte unsigned q0[$], q1[$], exp0[$], exp1[$];
    int           pk0_tlen[$], pk0_left[$];
    pkt_t         pkts[$];
    vec_t         vecs[6];

    int  ncmp = 0;
    int  nfail = 0;
    int  cyc = 0;
    int  cur_n = 0, cur_tlen = 0, cur_tid = 0, cur_first = 0;
    bit  hs0, hs1, s0_pend, s1_pend, prev_stall;
    bit  ready_rand, s0_gap, s1_gap;
    logic [22:0] prev_out;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_s0(input int field, input int nbytes);
        byte unsigned b;
        pk0_tlen.push_back(field);
        pk0_left.push_back(nbytes);
        for (int i = 0; i < nbytes; i++) begin
            b = byte'($urandom);
            q0.push_back(b);
            exp0.push_back(b);
        end
    endtask

    task automatic push_s1(input int nbytes);
        byte unsigned b;
        for (int i = 0; i < nbytes; i++) begin
            b = byte'($urandom);
            q1.push_back(b);
            exp1.push_back(b);
        end
    endtask

    // Record one USB-side byte and check it against the source scoreboards
    task automatic monitor_byte();
        byte unsigned e;
        if (cur_n == 0) begin
            cur_tlen  = int'(m_tlen);
            cur_tid   = int'(m_tid);
            cur_first = cyc;
        end else begin
            checkOutput("tlen_const", 32'(m_tlen), cur_tlen);
            checkOutput("tid_const", 32'(m_tid), cur_tid);
        end
        e = 8'h00;
        if (m_tid == 1'b0) begin
            checkOutput("data_avail0", 32'(exp0.size() > 0), 1);
            if (exp0.size() > 0) e = exp0.pop_front();
        end else begin
            checkOutput("data_avail1", 32'(exp1.size() > 0), 1);
            if (exp1.size() > 0) e = exp1.pop_front();
        end
        checkOutput("data", 32'(m_tdata), 32'(e));
        cur_n++;
        checkOutput("tlast", 32'(m_tlast), 32'(cur_n == cur_tlen));
        if (m_tlast) begin
            pkts.push_back('{cur_tid, cur_tlen, cur_n, cur_first, cyc});
            cur_n = 0;
        end
    endtask

    // One clock: retire last cycle's handshakes, drive inputs at negedge, sample
    task automatic applyStimulus();
        byte unsigned b;
        @(negedge hclk);
        if (hs0) begin
            b = q0.pop_front();
            pk0_left[0] = pk0_left[0] - 1;
            if (pk0_left[0] == 0) begin
                void'(pk0_left.pop_front());
                void'(pk0_tlen.pop_front());
            end
        end
        if (hs1) b = q1.pop_front();
        m_tready  = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        s0_tvalid = (q0.size() > 0) && (s0_pend || !(s0_gap && ($urandom_range(0, 2) == 0)));
        s0_tdata  = (q0.size() > 0) ? q0[0] : 8'h00;
        s0_tlen   = (pk0_tlen.size() > 0) ? LEN_W'(pk0_tlen[0]) : '0;
        s1_tvalid = (q1.size() > 0) && (s1_pend || !(s1_gap && ($urandom_range(0, 2) == 0)));
        s1_tdata  = (q1.size() > 0) ? q1[0] : 8'h00;
        s1_count  = LEN_W'(q1.size());
        #1;
        cyc++;
        hs0     = s0_tvalid && s0_tready;
        hs1     = s1_tvalid && s1_tready;
        s0_pend = s0_tvalid && !s0_tready;
        s1_pend = s1_tvalid && !s1_tready;
        if (prev_stall) begin
            checkOutput("stall_hold", 32'({m_tvalid, m_tdata, m_tlen, m_tid, m_tlast}), 32'(prev_out));
        end
        prev_stall = m_tvalid && !m_tready;
        prev_out   = {m_tvalid, m_tdata, m_tlen, m_tid, m_tlast};
        if (m_tvalid && m_tready) monitor_byte();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b1;
        ready_rand = 1'b0;
        s0_gap = 1'b0;
        s1_gap = 1'b0;
        q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
        pk0_tlen.delete(); pk0_left.delete(); pkts.delete();
        cur_n = 0;
        hs0 = 1'b0; hs1 = 1'b0; s0_pend = 1'b0; s1_pend = 1'b0; prev_stall = 1'b0;
        applyStimulus();
        applyStimulus();
    endtask

    task automatic release_reset();
        applyStimulus();
        reset = 1'b0;
    endtask

    task automatic wait_pkt(input int budget, output pkt_t p);
        p = '{-1, 0, 0, 0, 0};
        for (int i = 0; i < budget && pkts.size() == 0; i++) applyStimulus();
        if (pkts.size() > 0) begin
            p = pkts.pop_front();
        end else begin
            ncmp++;
            nfail++;
            $display("[TB] FAIL pkt_timeout: got no packet expected one within %0d cycles", budget);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        pkt_t p, big, tail;
        int   nval;

        vecs = '{'{64, 64, 1'b0, 1'b0},
                 '{1, 1, 1'b0, 1'b0},
                 '{0, 1, 1'b1, 1'b0},
                 '{1000, 512, 1'b1, 1'b0},
                 '{512, 512, 1'b0, 1'b1},
                 '{513, 512, 1'b1, 1'b1}};

        // Reset state
        do_reset();
        checkOutput("reset_outs", 32'({m_tvalid, m_tlast, m_tlen, m_tid, s0_tready, s1_tready, busy, err_len}), 0);

        // Single DAP packets, including clamped lengths
        foreach (vecs[k]) begin
            do_reset();
            ready_rand = vecs[k].bp;
            s0_gap     = vecs[k].bp;
            push_s0(vecs[k].tlen_field, vecs[k].exp_len);
            release_reset();
            wait_pkt(3000, p);
            checkOutput("v_tid", p.tid, 0);
            checkOutput("v_len", p.len, vecs[k].exp_len);
            checkOutput("v_nbytes", p.n, vecs[k].exp_len);
            checkOutput("v_err_len", 32'(err_len), 32'(vecs[k].exp_err));
            applyStimulus();
            checkOutput("v_busy_after", 32'(busy), 0);
        end

        // Partial stream chunk flushed only after the idle timeout
        do_reset();
        push_s1(20);
        release_reset();
        nval = 0;
        for (int i = 0; i < 64; i++) begin
            applyStimulus();
            if (m_tvalid) nval++;
        end
        checkOutput("flush_quiet", nval, 0);
        applyStimulus();
        checkOutput("flush_valid", 32'(m_tvalid), 1);
        checkOutput("flush_tid", 32'(m_tid), 1);
        checkOutput("flush_tlen", 32'(m_tlen), 20);
        push_s1(10);
        wait_pkt(100, p);
        checkOutput("flush_len", p.len, 20);
        checkOutput("flush_nbytes", p.n, 20);

        // Contention: DAP first, full stream chunk, late DAP, then timed-out tail
        do_reset();
        push_s0(10, 10);
        push_s1(600);
        release_reset();
        wait_pkt(100, p);
        checkOutput("rr_first_tid", p.tid, 0);
        checkOutput("rr_first_len", p.len, 10);
        for (int i = 0; i < 10 && !(busy && m_tid); i++) applyStimulus();
        push_s0(7, 7);
        wait_pkt(1000, big);
        checkOutput("rr_big_tid", big.tid, 1);
        checkOutput("rr_big_len", big.len, 512);
        wait_pkt(100, p);
        checkOutput("rr_late_tid", p.tid, 0);
        checkOutput("rr_late_len", p.len, 7);
        wait_pkt(200, tail);
        checkOutput("rr_tail_tid", tail.tid, 1);
        checkOutput("rr_tail_len", tail.len, 88);
        checkOutput("rr_tail_gap", tail.first - big.last, 66);

        // Backpressure and stream gaps on a full chunk
        do_reset();
        ready_rand = 1'b1;
        s1_gap     = 1'b1;
        push_s1(512);
        release_reset();
        wait_pkt(6000, p);
        checkOutput("bp_tid", p.tid, 1);
        checkOutput("bp_len", p.len, 512);
        checkOutput("bp_nbytes", p.n, 512);
        checkOutput("bp_exp_left", exp1.size(), 0);

        // Enable dropped mid-packet: packet finishes, nothing new until re-enabled
        do_reset();
        push_s0(40, 40);
        release_reset();
        for (int i = 0; i < 100 && cur_n < 10; i++) applyStimulus();
        checkOutput("en_progress", 32'(cur_n >= 10), 1);
        enable = 1'b0;
        push_s1(600);
        wait_pkt(100, p);
        checkOutput("en_len", p.len, 40);
        checkOutput("en_nbytes", p.n, 40);
        nval = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus();
            if (m_tvalid || busy) nval++;
        end
        checkOutput("en_quiet", nval, 0);
        enable = 1'b1;
        wait_pkt(1000, p);
        checkOutput("en_resume_tid", p.tid, 1);
        checkOutput("en_resume_len", p.len, 512);

        // Reset in the middle of a DAP packet
        do_reset();
        push_s0(0, 1);
        push_s0(300, 300);
        release_reset();
        wait_pkt(100, p);
        checkOutput("rst_pre_err", 32'(err_len), 1);
        for (int i = 0; i < 400 && cur_n < 100; i++) applyStimulus();
        checkOutput("rst_progress", cur_n, 100);
        reset = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_outs", 32'({m_tvalid, m_tlast, m_tlen, m_tid, s0_tready, s1_tready, busy, err_len}), 0);
        do_reset();
        push_s1(600);
        push_s0(8, 8);
        release_reset();
        wait_pkt(100, p);
        checkOutput("rst_fresh_tid", p.tid, 0);
        checkOutput("rst_fresh_len", p.len, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/usb_in_arbiter.md
Name: usb_in_arbiter

Overview:
- Shares the single WinUSB bulk-IN packet path of the USB device between two requesters.
- Requester 0 is the DAP response stream: byte stream with the packet length presented on the first byte.
- Requester 1 is a byte FIFO stream (SWO/trace capture) with no framing; the arbiter chunks it into packets of at most MAX_PKT bytes, flushing partial chunks after an idle timeout.
- Sits between the DAP controller / trace FIFO and the USB device's winusb_in_* interface. Grants are packet-atomic and round-robin.

Parameters:
- MAX_PKT, 512: maximum bytes per output packet (high-speed bulk MPS).
- LEN_W, 12: width of length and count fields.
- FLUSH_TIMEOUT, 64: hclk cycles a non-empty, non-full src1 FIFO waits before a partial packet is forced.

Ports:
- hclk  in  1  clock
- reset  in  1  synchronous active-high reset
- enable  in  1  permits new grants; does not abort an active packet
- s0_tvalid  in  1  src0 byte valid
- s0_tready  out  1  src0 byte accepted
- s0_tdata  in  8  src0 byte
- s0_tlen  in  LEN_W  src0 packet length; valid with the first byte, stable until the last byte
- s1_tvalid  in  1  src1 byte valid
- s1_tready  out  1  src1 byte accepted
- s1_tdata  in  8  src1 byte
- s1_count  in  LEN_W  src1 FIFO fill level
- m_tvalid  out  1  output byte valid
- m_tready  in  1  USB side accepts byte
- m_tdata  out  8  output byte
- m_tlen  out  LEN_W  current packet length; constant for the whole packet
- m_tlast  out  1  last byte of packet
- m_tid  out  1  source of current packet (0 = DAP, 1 = stream)
- busy  out  1  packet in progress
- err_len  out  1  sticky: src0 length out of range

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0: m_tvalid, m_tlast, m_tlen, m_tid, s0_tready, s1_tready, busy, err_len.
  - last_grant = 1, so src0 wins the first tie.
  - Flush timer = 0.
- Requests in IDLE:
  - req0 = enable & s0_tvalid.
  - req1 = enable & (s1_count != 0) & (s1_count >= MAX_PKT | timer == FLUSH_TIMEOUT).
- Flush timer:
  - Increments each cycle while s1_count != 0 and no src1 packet is active.
  - Saturates at FLUSH_TIMEOUT.
  - Cleared when s1_count == 0, and cleared on grant to src1.
- Arbitration (IDLE only, registered):
  - Single request: grant that source.
  - Both requesting: grant the source != last_grant.
  - On grant:
    - last_grant <= id; m_tid <= id.
    - len <= src0: s0_tlen clamped to 1..MAX_PKT; src1: min(s1_count, MAX_PKT).
    - remaining <= len.
    - State <= XFER0 or XFER1.
  - Grant is visible one cycle after the request: a request sampled at edge N produces busy = 1 and a possible m_tvalid in cycle N+1.
- src0 length errors:
  - s0_tlen == 0 or > MAX_PKT sets err_len.
  - err_len clears only on reset.
- XFER states:
  - Data path: m_tvalid = sel_tvalid; sel_tready = m_tready; m_tdata = sel_tdata.
  - The unselected source's tready is 0.
  - m_tlen holds len; m_tlast = (remaining == 1).
  - Each m_tvalid & m_tready decrements remaining.
  - The handshake with remaining == 1 returns the state to IDLE.
  - One idle cycle is required between packets; back-to-back grants are not required.
- Boundary conditions:
  - enable falling mid-packet: the packet completes; no new grant.
  - s1_count rising during XFER1: the latched len is unaffected.
  - src1 valid dropping mid-packet: a stall, not an abort; src1 guarantees len bytes because count was sampled.
  - src0 tvalid gaps: stall.
  - m_tready low: hold all outputs stable (AXI-Stream rules).
  - Reset mid-packet: immediate IDLE; the partial packet is discarded. Upstream FIFOs and the USB core reset on the same reset.
- busy = (state != IDLE).

Decomposition:
- Package usb_in_arb_pkg:
  - State enum IDLE / XFER0 / XFER1.
  - TID_DAP = 0, TID_STREAM = 1.
  - LEN_W and MAX_PKT defaults.
  - Clamp function for lengths.
- Sub-module rr_arb2: 2-request round-robin grant with last_grant register.
- Remaining logic (timer, length latch, mux, counter) stays in the top.

Test Plan:
- src0 only, s0_tlen = 64, 64 bytes, m_tready = 1:
  - m_tlen = 64 and m_tid = 0 throughout.
  - m_tlast on byte 64.
  - busy returns low the cycle after.
- src1 count = 20, no new data:
  - No m_tvalid for 64 cycles.
  - Grant on the cycle after the timer saturates.
  - m_tlen = 20, m_tid = 1.
  - m_tlast on byte 20.
- s1_count = 600 and s0 packet (len 10) both pending at the same edge after reset:
  - src0 packet first (len 10).
  - Then a src1 packet of len 512.
  - Then the remaining 88 bytes only after timeout.
  - A new src0 request waiting at the end of the 512-byte packet wins before the 88-byte tail.
- Random m_tready backpressure (50%) on a 512-byte src1 packet:
  - m_tdata/m_tlen stable while stalled.
  - Exactly 512 handshakes; order matches input.
- s0_tlen = 0 and separately s0_tlen = 1000:
  - err_len = 1.
  - Lengths clamp to 1 and 512 respectively.
- Reset asserted at byte 100 of a 300-byte src0 packet:
  - Next cycle all outputs 0, state IDLE, err_len = 0.
  - A fresh packet after reset goes to src0.
